// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART receiver.
package uart_pkg;

    localparam int   DATA_BITS  = 8;
    localparam logic STOP_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        CLEANUP,
        BREAK_WAIT
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RX pad; resets to the idle (high) level.
module uart_rx_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync
);

    logic [1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_async};
        end
    end

    assign o_sync = r_sync[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled by clk_per_bit, each bit sampled at its midpoint.
module uart_rx
    import uart_pkg::*;
#(
    parameter int clk_per_bit = 87
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx_serial,
    output logic       o_rx_dv,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_frame_err
);

    localparam int             CW       = $clog2(clk_per_bit);
    localparam int             IW       = $clog2(DATA_BITS);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(clk_per_bit - 1);
    localparam logic [CW-1:0]  HALF_CNT = CW'((clk_per_bit - 1) / 2);
    localparam logic [IW-1:0]  LAST_IDX = IW'(DATA_BITS - 1);

    logic                  w_rx;
    rx_state_t             r_state;
    rx_state_t             w_state_next;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_next;
    logic [IW-1:0]         r_idx;
    logic [IW-1:0]         w_idx_next;
    logic [DATA_BITS-1:0]  r_shift;
    logic [DATA_BITS-1:0]  w_shift_next;
    logic [DATA_BITS-1:0]  r_byte;
    logic [DATA_BITS-1:0]  w_byte_next;
    logic                  r_dv;
    logic                  w_dv_next;
    logic                  r_ferr;
    logic                  w_ferr_next;
    logic                  w_half_done;
    logic                  w_bit_done;

    uart_rx_sync u_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_rx_serial),
        .o_sync  (w_rx)
    );

    assign w_half_done = (r_cnt == HALF_CNT);
    assign w_bit_done  = (r_cnt == CNT_MAX);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:       if (!w_rx) w_state_next = START;
            START:      if (w_half_done) w_state_next = w_rx ? IDLE : DATA;
            DATA:       if (w_bit_done && r_idx == LAST_IDX) w_state_next = STOP;
            STOP:       if (w_bit_done) w_state_next = (w_rx == STOP_LEVEL) ? CLEANUP : BREAK_WAIT;
            CLEANUP:    w_state_next = IDLE;
            BREAK_WAIT: if (w_rx) w_state_next = IDLE;
            default:    w_state_next = IDLE;
        endcase
    end

    // Counter restarts from zero in every state unless it is still timing a bit.
    always_comb begin
        w_cnt_next   = '0;
        w_idx_next   = r_idx;
        w_shift_next = r_shift;
        w_byte_next  = r_byte;
        w_dv_next    = 1'b0;
        w_ferr_next  = 1'b0;
        case (r_state)
            START: begin
                if (!w_half_done) begin
                    w_cnt_next = r_cnt + 1'b1;
                end else begin
                    w_idx_next = '0;
                end
            end
            DATA: begin
                if (!w_bit_done) begin
                    w_cnt_next = r_cnt + 1'b1;
                end else begin
                    w_shift_next[r_idx] = w_rx;
                    w_idx_next          = r_idx + 1'b1;
                end
            end
            STOP: begin
                if (!w_bit_done) begin
                    w_cnt_next = r_cnt + 1'b1;
                end else if (w_rx == STOP_LEVEL) begin
                    w_byte_next = r_shift;
                    w_dv_next   = 1'b1;
                end else begin
                    w_ferr_next = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_byte  <= '0;
            r_dv    <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_shift <= w_shift_next;
            r_byte  <= w_byte_next;
            r_dv    <= w_dv_next;
            r_ferr  <= w_ferr_next;
        end
    end

    assign o_rx_dv        = r_dv;
    assign o_rx_byte      = r_byte;
    assign o_rx_frame_err = r_ferr;

endmodule

// File: tb/tb_uart_rx.sv
// Directed scoreboard bench for uart_rx at the default rate and at clk_per_bit=4.
module tb_uart_rx;

    localparam int CPB_S = 87;
    localparam int CPB_F = 4;

    logic       clk;
    logic       rst;
    logic       rx_s;
    logic       rx_f;
    logic       dv_s;
    logic       dv_f;
    logic       ferr_s;
    logic       ferr_f;
    logic [7:0] byte_s;
    logic [7:0] byte_f;

    int tests;
    int fails;
    int cyc;
    int n_dv_s;
    int n_dv_f;
    int n_ferr_s;
    int start_cyc;
    bit prev_dv_s;
    bit prev_dv_f;
    logic [7:0] exp_q_s[$];
    logic [7:0] exp_q_f[$];
    int         dv_cyc_s[$];

    uart_rx #(.clk_per_bit(CPB_S)) u_dut_s (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_rx_serial    (rx_s),
        .o_rx_dv        (dv_s),
        .o_rx_byte      (byte_s),
        .o_rx_frame_err (ferr_s)
    );

    uart_rx #(.clk_per_bit(CPB_F)) u_dut_f (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_rx_serial    (rx_f),
        .o_rx_dv        (dv_f),
        .o_rx_byte      (byte_f),
        .o_rx_frame_err (ferr_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitors: pop the scoreboard on each valid pulse and enforce single-cycle pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_dv_s) check("dv_s_width", 32'(dv_s), 32'd0);
            if (dv_s || ferr_s) check("dv_ferr_excl", 32'(dv_s && ferr_s), 32'd0);
            if (ferr_s) n_ferr_s++;
            if (dv_s) begin
                n_dv_s++;
                dv_cyc_s.push_back(cyc);
                if (exp_q_s.size() == 0) begin
                    check("unexpected_dv_s", 32'(byte_s), 32'hFFFF_FFFF);
                end else begin
                    check("byte_s", 32'(byte_s), 32'(exp_q_s.pop_front()));
                end
            end
            if (prev_dv_f) check("dv_f_width", 32'(dv_f), 32'd0);
            if (dv_f) begin
                n_dv_f++;
                if (exp_q_f.size() == 0) begin
                    check("unexpected_dv_f", 32'(byte_f), 32'hFFFF_FFFF);
                end else begin
                    check("byte_f", 32'(byte_f), 32'(exp_q_f.pop_front()));
                end
            end
        end
        prev_dv_s = dv_s;
        prev_dv_f = dv_f;
    end

    task automatic drive(input bit fast, input logic v, input int n);
        if (fast) rx_f = v;
        else      rx_s = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit fast, input int stop_low, input int rst_bit);
        int cpb;
        cpb = fast ? CPB_F : CPB_S;
        start_cyc = cyc;
        drive(fast, 1'b0, cpb);
        for (int i = 0; i < 8; i++) begin
            if (i == rst_bit) begin
                drive(fast, b[i], cpb / 2);
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                drive(fast, b[i], cpb - cpb / 2 - 1);
            end else begin
                drive(fast, b[i], cpb);
            end
        end
        if (stop_low > 0) drive(fast, 1'b0, cpb * stop_low);
        drive(fast, 1'b1, cpb);
    endtask

    initial begin
        int n0;
        int k;
        tests    = 0;
        fails    = 0;
        cyc      = 0;
        n_dv_s   = 0;
        n_dv_f   = 0;
        n_ferr_s = 0;
        rx_s     = 1'b1;
        rx_f     = 1'b1;
        rst      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_dv", 32'(dv_s), 32'd0);
        check("rst_ferr", 32'(ferr_s), 32'd0);
        check("rst_byte", 32'(byte_s), 32'h00);
        repeat (10) @(posedge clk);
        #1;

        // 1: single 0xA5 frame
        n0 = n_dv_s;
        exp_q_s.push_back(8'hA5);
        send(8'hA5, 1'b0, 0, -1);
        repeat (5) @(posedge clk);
        #1;
        check("t1_ndv", 32'(n_dv_s), 32'(n0 + 1));
        check("t1_latency_ok", 32'((dv_cyc_s[dv_cyc_s.size()-1] - start_cyc) inside {[828:832]}), 32'd1);
        check("t1_ferr", 32'(n_ferr_s), 32'd0);
        $display("[TB] frame 0xA5 done, dv count %0d", n_dv_s);

        // 2: back-to-back 0x00, 0xFF
        k = dv_cyc_s.size();
        exp_q_s.push_back(8'h00);
        exp_q_s.push_back(8'hFF);
        send(8'h00, 1'b0, 0, -1);
        send(8'hFF, 1'b0, 0, -1);
        repeat (5) @(posedge clk);
        #1;
        check("t2_ndv", 32'(dv_cyc_s.size()), 32'(k + 2));
        if (dv_cyc_s.size() >= k + 2)
            check("t2_spacing", 32'(dv_cyc_s[k+1] - dv_cyc_s[k]), 32'(10 * CPB_S));
        check("t2_byte", 32'(byte_s), 32'hFF);
        $display("[TB] back-to-back 0x00/0xFF done, dv count %0d", n_dv_s);

        // 3: short glitch, then 0x3C
        n0 = n_dv_s;
        drive(1'b0, 1'b0, 20);
        drive(1'b0, 1'b1, 300);
        check("t3_glitch_ndv", 32'(n_dv_s), 32'(n0));
        check("t3_glitch_ferr", 32'(n_ferr_s), 32'd0);
        exp_q_s.push_back(8'h3C);
        send(8'h3C, 1'b0, 0, -1);
        repeat (5) @(posedge clk);
        #1;
        check("t3_ndv", 32'(n_dv_s), 32'(n0 + 1));
        $display("[TB] glitch + frame 0x3C done, dv count %0d", n_dv_s);

        // 4: framing error with held-low stop, then 0x81
        n0 = n_dv_s;
        send(8'h5A, 1'b0, 3, -1);
        repeat (20) @(posedge clk);
        #1;
        check("t4_ferr_cnt", 32'(n_ferr_s), 32'd1);
        check("t4_ndv", 32'(n_dv_s), 32'(n0));
        check("t4_byte_kept", 32'(byte_s), 32'h3C);
        exp_q_s.push_back(8'h81);
        send(8'h81, 1'b0, 0, -1);
        repeat (5) @(posedge clk);
        #1;
        check("t4_after_ndv", 32'(n_dv_s), 32'(n0 + 1));
        $display("[TB] frame error + frame 0x81 done, ferr count %0d", n_ferr_s);

        // 5: reset during data bit 4, then 0xC3
        n0 = n_dv_s;
        send(8'hFF, 1'b0, 0, 4);
        repeat (20) @(posedge clk);
        #1;
        check("t5_ndv", 32'(n_dv_s), 32'(n0));
        check("t5_byte_rst", 32'(byte_s), 32'h00);
        exp_q_s.push_back(8'hC3);
        send(8'hC3, 1'b0, 0, -1);
        repeat (5) @(posedge clk);
        #1;
        check("t5_after_ndv", 32'(n_dv_s), 32'(n0 + 1));
        check("t5_byte", 32'(byte_s), 32'hC3);
        $display("[TB] reset abort + frame 0xC3 done, dv count %0d", n_dv_s);

        // 6: fast instance, clk_per_bit=4
        exp_q_f.push_back(8'h96);
        drive(1'b1, 1'b1, 10);
        send(8'h96, 1'b1, 0, -1);
        repeat (5) @(posedge clk);
        #1;
        check("t6_ndv", 32'(n_dv_f), 32'd1);
        check("t6_byte", 32'(byte_f), 32'h96);
        $display("[TB] fast frame 0x96 done, dv count %0d", n_dv_f);

        check("sb_empty_s", 32'(exp_q_s.size()), 32'd0);
        check("sb_empty_f", 32'(exp_q_f.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
